// File: rtl/fir_pkg.sv
// fir_pkg: register map, ap_ctrl bit positions and sequencer states shared by the FIR configuration logic
package fir_pkg;
   localparam logic [11:0] FIR_AP_CTRL  = 12'h00;
   localparam logic [11:0] FIR_LENGTH   = 12'h10;
   localparam logic [11:0] FIR_TAP_BASE = 12'h20;
   localparam int AP_START_BIT = 0;
   localparam int AP_DONE_BIT  = 1;
   localparam int AP_IDLE_BIT  = 2;
   typedef enum logic [3:0] {
      S_IDLE, S_CHK_RD, S_CHK_WAIT, S_WR_LEN, S_TAP_GET, S_TAP_PUT,
      S_WR_START, S_WR_CLR, S_POLL_RD, S_POLL_WAIT, S_DONE
   } fir_seq_state_t;
endpackage

// File: rtl/fir_cfg_sequencer_if.sv
// fir_cfg_sequencer_if: AXI4-Lite write-address/write-data/read channels without a write response
interface fir_cfg_sequencer_if #(parameter int AW = 12, parameter int DW = 32) ();
   logic          awvalid;
   logic          awready;
   logic [AW-1:0] awaddr;
   logic          wvalid;
   logic          wready;
   logic [DW-1:0] wdata;
   logic          arvalid;
   logic          arready;
   logic [AW-1:0] araddr;
   logic          rvalid;
   logic          rready;
   logic [DW-1:0] rdata;
   modport master (output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
                   input awready, wready, arready, rvalid, rdata);
   modport slave (input awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
                  output awready, wready, arready, rvalid, rdata);
endinterface

// File: rtl/fir_cfg_sequencer_axil_master_port.sv
// axil_master_port: single-outstanding AXI4-Lite beat engine launched by a one-cycle req pulse
module axil_master_port #(
   parameter int AW = 12,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic          ack,
   output logic [DW-1:0] rdata,
   fir_cfg_sequencer_if.master bus
);
   // launch a beat on req, retire it on handshake; ack lands in the release cycle so beats are spaced by two
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.awvalid <= 1'b0;
         bus.wvalid  <= 1'b0;
         bus.awaddr  <= '0;
         bus.wdata   <= '0;
         bus.arvalid <= 1'b0;
         bus.araddr  <= '0;
         bus.rready  <= 1'b0;
         ack         <= 1'b0;
         rdata       <= '0;
      end else begin
         ack <= 1'b0;
         if (req && we) begin
            bus.awvalid <= 1'b1;
            bus.wvalid  <= 1'b1;
            bus.awaddr  <= addr;
            bus.wdata   <= wdata;
         end
         if (req && !we) begin
            bus.arvalid <= 1'b1;
            bus.araddr  <= addr;
         end
         if (bus.awvalid && bus.awready && bus.wready) begin
            bus.awvalid <= 1'b0;
            bus.wvalid  <= 1'b0;
            ack         <= 1'b1;
         end
         if (bus.arvalid && bus.arready) begin
            bus.arvalid <= 1'b0;
            bus.rready  <= 1'b1;
         end
         if (bus.rready && bus.rvalid) begin
            bus.rready <= 1'b0;
            rdata      <= bus.rdata;
            ack        <= 1'b1;
         end
      end
   end
endmodule

// File: rtl/fir_cfg_sequencer.sv
// fir_cfg_sequencer: AXI4-Lite master that loads length and taps into the FIR, starts it and polls for completion
module fir_cfg_sequencer
   import fir_pkg::*;
#(
   parameter int pADDR_WIDTH = 12,
   parameter int pDATA_WIDTH = 32,
   parameter int Tape_Num    = 11,
   parameter int POLL_GAP    = 4,
   parameter int POLL_MAX    = 1023
) (
   input  logic                   axis_clk,
   input  logic                   axis_rst,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [pDATA_WIDTH-1:0] cmd_length,
   input  logic                   coef_valid,
   output logic                   coef_ready,
   input  logic [pDATA_WIDTH-1:0] coef_data,
   fir_cfg_sequencer_if.master    bus,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);
   localparam int GW = $clog2(POLL_GAP + 1);
   localparam int CW = $clog2(POLL_MAX + 1);
   localparam int IW = $clog2(Tape_Num + 1);
   fir_seq_state_t state, state_n;
   logic [pDATA_WIDTH-1:0] len;
   logic [IW-1:0] idx;
   logic [CW-1:0] rd_cnt;
   logic [GW-1:0] gap_cnt;
   logic req, we, ack;
   logic [pADDR_WIDTH-1:0] addr;
   logic [pDATA_WIDTH-1:0] wdata, rdata;
   logic last_rd, gap_end, rd_state;
   assign last_rd  = rd_cnt == CW'(POLL_MAX - 1);
   assign gap_end  = gap_cnt == GW'(POLL_GAP - 1);
   assign rd_state = state == S_CHK_RD || state == S_POLL_RD;
   assign cmd_ready  = state == S_IDLE;
   assign coef_ready = state == S_TAP_GET;
   assign busy       = state != S_IDLE;
   assign done       = state == S_DONE;
   // a beat is launched on the transition into an issuing state so its valid rises in that state's first cycle
   assign req = state_n != state && (state_n inside {S_CHK_RD, S_WR_LEN, S_TAP_PUT, S_WR_START, S_WR_CLR, S_POLL_RD});
   assign we  = !(state_n inside {S_CHK_RD, S_POLL_RD});
   assign addr = state_n == S_WR_LEN ? pADDR_WIDTH'(FIR_LENGTH) :
                 state_n == S_TAP_PUT ? pADDR_WIDTH'(FIR_TAP_BASE) + (pADDR_WIDTH'(idx) << 2) :
                 pADDR_WIDTH'(FIR_AP_CTRL);
   assign wdata = state_n == S_WR_LEN ? len :
                  state_n == S_TAP_PUT ? coef_data :
                  state_n == S_WR_START ? pDATA_WIDTH'(1) << AP_START_BIT : '0;
   axil_master_port #(.AW(pADDR_WIDTH), .DW(pDATA_WIDTH)) u_port (
      .clk(axis_clk), .rst(axis_rst), .req(req), .we(we), .addr(addr),
      .wdata(wdata), .ack(ack), .rdata(rdata), .bus(bus)
   );
   // state register
   always_ff @(posedge axis_clk or posedge axis_rst) begin
      if (axis_rst) state <= S_IDLE;
      else state <= state_n;
   end
   // next-state: every bus state waits for the port ack; failed status reads retry after a gap until the read budget runs out
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:      if (cmd_valid) state_n = S_CHK_RD;
         S_CHK_RD:    if (ack) state_n = rdata[AP_IDLE_BIT] ? S_WR_LEN : last_rd ? S_IDLE : S_CHK_WAIT;
         S_CHK_WAIT:  if (gap_end) state_n = S_CHK_RD;
         S_WR_LEN:    if (ack) state_n = S_TAP_GET;
         S_TAP_GET:   if (coef_valid) state_n = S_TAP_PUT;
         S_TAP_PUT:   if (ack) state_n = idx == IW'(Tape_Num - 1) ? S_WR_START : S_TAP_GET;
         S_WR_START:  if (ack) state_n = S_WR_CLR;
         S_WR_CLR:    if (ack) state_n = S_POLL_RD;
         S_POLL_RD:   if (ack) state_n = rdata[AP_DONE_BIT] ? S_DONE : last_rd ? S_IDLE : S_POLL_WAIT;
         S_POLL_WAIT: if (gap_end) state_n = S_POLL_RD;
         S_DONE:      state_n = S_IDLE;
         default:     state_n = S_IDLE;
      endcase
   end
   // command context, tap index, read budget, poll gap timer and the sticky timeout flag
   always_ff @(posedge axis_clk or posedge axis_rst) begin
      if (axis_rst) begin
         len     <= '0;
         idx     <= '0;
         rd_cnt  <= '0;
         gap_cnt <= '0;
         err     <= 1'b0;
      end else begin
         if (state == S_IDLE && cmd_valid) begin
            len <= cmd_length;
            idx <= '0;
            err <= 1'b0;
         end
         if (state == S_TAP_PUT && ack) idx <= idx + 1'b1;
         if ((state == S_IDLE || state == S_WR_CLR) && state_n != state) rd_cnt <= '0;
         else if (rd_state && ack) rd_cnt <= rd_cnt + 1'b1;
         gap_cnt <= (state == S_CHK_WAIT || state == S_POLL_WAIT) ? gap_cnt + 1'b1 : '0;
         if (rd_state && ack && state_n == S_IDLE) err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_fir_cfg_sequencer.sv
// tb_fir_cfg_sequencer: directed runs against a scripted AXI4-Lite FIR slave with hand-derived expectations
module tb_fir_cfg_sequencer;
   localparam int GAP = 4;
   localparam int PMAX = 8;
   localparam int TAPS = 11;
   logic axis_clk = 0;
   logic axis_rst = 1;
   logic cmd_valid = 0;
   logic cmd_ready;
   logic [31:0] cmd_length = 0;
   logic coef_valid = 0;
   logic coef_ready;
   logic [31:0] coef_data = 0;
   logic busy, done, err;
   always #5 axis_clk = ~axis_clk;
   fir_cfg_sequencer_if #(.AW(12), .DW(32)) bus ();
   fir_cfg_sequencer #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .Tape_Num(TAPS), .POLL_GAP(GAP), .POLL_MAX(PMAX)) dut (
      .axis_clk(axis_clk), .axis_rst(axis_rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_length(cmd_length), .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_data(coef_data),
      .bus(bus), .busy(busy), .done(done), .err(err)
   );
   int coef [TAPS] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
   int n_tests = 0;
   int n_fail = 0;
   int not_idle = 0;
   int done_on = 1;
   int bp_stall = 0;
   logic [11:0] bp_addr = 12'hFFF;
   logic clr = 0;
   logic quiet = 0;
   logic [43:0] wlog [$];
   int cyc = 0;
   int chk_reads, poll_reads, sixth_rd_cyc, first_wr_cyc, last_rd_cyc, min_gap;
   int bp_left, stall_seen, bp_bad, quiet_act, bad_ar, done_cnt;
   logic start_seen;
   assign bus.awready = 1'b1;
   assign bus.arready = 1'b1;
   assign bus.wready = !(bus.awvalid && bus.awaddr == bp_addr && bp_left != 0);
   // scripted slave: logs write beats, answers status reads, tracks timing of reads and stalls
   always @(posedge axis_clk) begin
      cyc <= cyc + 1;
      if (clr) begin
         wlog.delete();
         chk_reads <= 0;
         poll_reads <= 0;
         sixth_rd_cyc <= -1;
         first_wr_cyc <= -1;
         last_rd_cyc <= -1;
         min_gap <= 1000;
         bp_left <= bp_stall;
         stall_seen <= 0;
         bp_bad <= 0;
         quiet_act <= 0;
         bad_ar <= 0;
         start_seen <= 0;
         bus.rvalid <= 0;
         bus.rdata <= 0;
      end else if (axis_rst) begin
         bus.rvalid <= 0;
      end else begin
         if (bus.awvalid && bus.wvalid && bus.wready) begin
            wlog.push_back({bus.awaddr, bus.wdata});
            if (first_wr_cyc < 0) first_wr_cyc <= cyc;
            if (bus.awaddr == 12'h0 && bus.wdata == 32'h1) start_seen <= 1;
         end
         if (bus.awvalid && !bus.wready) begin
            bp_left <= bp_left - 1;
            stall_seen <= stall_seen + 1;
            if (bus.awaddr != 12'h2C || bus.wdata != 32'(coef[3]) || !bus.wvalid) bp_bad <= bp_bad + 1;
         end
         if (bus.rvalid && bus.rready) bus.rvalid <= 0;
         if (bus.arvalid) begin
            bus.rvalid <= 1;
            if (bus.araddr != 12'h0) bad_ar <= bad_ar + 1;
            if (!start_seen) begin
               bus.rdata <= (chk_reads < not_idle) ? 32'h0 : 32'h4;
               chk_reads <= chk_reads + 1;
               if (chk_reads == 5) sixth_rd_cyc <= cyc;
               if (last_rd_cyc >= 0 && cyc - last_rd_cyc < min_gap) min_gap <= cyc - last_rd_cyc;
               last_rd_cyc <= cyc;
            end else begin
               bus.rdata <= (done_on != 0 && poll_reads + 1 >= done_on) ? 32'h2 : 32'h0;
               poll_reads <= poll_reads + 1;
            end
         end
         if (quiet && (bus.awvalid || bus.arvalid)) quiet_act <= quiet_act + 1;
      end
   end
   // count done pulses away from the active edge
   always @(negedge axis_clk) begin
      if (clr) done_cnt <= 0;
      else if (done) done_cnt <= done_cnt + 1;
   end
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic clear_tb();
      @(negedge axis_clk);
      clr = 1;
      @(negedge axis_clk);
      clr = 0;
   endtask
   task automatic send_cmd(input logic [31:0] len);
      int t;
      t = 0;
      @(negedge axis_clk);
      cmd_valid = 1;
      cmd_length = len;
      while (!cmd_ready && t < 100) begin
         @(negedge axis_clk);
         t++;
      end
      check("cmd_ready", cmd_ready, 1);
      @(posedge axis_clk);
      #1 cmd_valid = 0;
   endtask
   task automatic feed(input int stall_after, input int stall_len);
      int t;
      for (int i = 0; i < TAPS; i++) begin
         t = 0;
         @(negedge axis_clk);
         coef_valid = 1;
         coef_data = 32'(coef[i]);
         while (!coef_ready && t < 200) begin
            @(negedge axis_clk);
            t++;
         end
         check("coef_ready", coef_ready, 1);
         @(posedge axis_clk);
         #1 coef_valid = 0;
         if (i == stall_after) begin
            t = 0;
            @(negedge axis_clk);
            while (!coef_ready && t < 200) begin
               @(negedge axis_clk);
               t++;
            end
            quiet = 1;
            repeat (stall_len) @(negedge axis_clk);
            quiet = 0;
         end
      end
   endtask
   task automatic finish_run();
      int t;
      t = 0;
      while (busy && t < 3000) begin
         @(negedge axis_clk);
         t++;
      end
      check("run_end_busy", busy, 0);
   endtask
   task automatic check_log(input logic [31:0] len, input int n);
      logic [43:0] exp [14];
      exp[0] = {12'h10, len};
      for (int i = 0; i < TAPS; i++) exp[i+1] = {12'(32 + 4 * i), 32'(coef[i])};
      exp[12] = {12'h0, 32'h1};
      exp[13] = {12'h0, 32'h0};
      check("log_size", wlog.size(), n);
      for (int i = 0; i < n && i < wlog.size(); i++) check($sformatf("wr%0d", i), wlog[i], exp[i]);
   endtask
   initial begin
      int t;
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int t;
      clear_tb();
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_coef_ready", coef_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.rready}, 0);
      @(negedge axis_clk);
      axis_rst = 0;
      done_on = 3;
      clear_tb();
      send_cmd(600);
      feed(-1, 0);
      finish_run();
      check_log(600, 14);
      check("nom_done_cnt", done_cnt, 1);
      check("nom_err", err, 0);
      check("nom_chk_reads", chk_reads, 1);
      check("nom_poll_reads", poll_reads, 3);
      check("nom_araddr", bad_ar, 0);
      not_idle = 5;
      done_on = 1;
      clear_tb();
      send_cmd(77);
      feed(-1, 0);
      finish_run();
      check("ni_chk_reads", chk_reads, 6);
      check("ni_wr_after_6th", first_wr_cyc > sixth_rd_cyc && sixth_rd_cyc >= 0, 1);
      check("ni_rd_gap", min_gap >= GAP + 2, 1);
      check("ni_done_cnt", done_cnt, 1);
      check_log(77, 14);
      not_idle = 0;
      bp_addr = 12'h2C;
      bp_stall = 7;
      clear_tb();
      send_cmd(300);
      feed(-1, 0);
      finish_run();
      check("bp_stall_cycles", stall_seen, 7);
      check("bp_unstable", bp_bad, 0);
      check("bp_done_cnt", done_cnt, 1);
      check_log(300, 14);
      bp_addr = 12'hFFF;
      bp_stall = 0;
      done_on = 0;
      clear_tb();
      send_cmd(5);
      feed(-1, 0);
      finish_run();
      check("to_poll_reads", poll_reads, PMAX);
      check("to_err", err, 1);
      check("to_done_cnt", done_cnt, 0);
      check("to_cmd_ready", cmd_ready, 1);
      check_log(5, 14);
      done_on = 2;
      clear_tb();
      send_cmd(1234);
      check("rec_err_cleared", err, 0);
      feed(-1, 0);
      finish_run();
      check("rec_done_cnt", done_cnt, 1);
      check("rec_err", err, 0);
      check("rec_poll_reads", poll_reads, 2);
      done_on = 1;
      clear_tb();
      send_cmd(600);
      feed(5, 20);
      finish_run();
      check("stall_bus_quiet", quiet_act, 0);
      check("stall_resume_addr", wlog.size() > 7 ? wlog[7][43:32] : 12'hFFF, 12'h38);
      check_log(600, 14);
      clear_tb();
      send_cmd(42);
      feed(-1, 0);
      t = 0;
      @(negedge axis_clk);
      while (!(bus.awvalid && bus.awaddr == 12'h0 && bus.wdata == 32'h1) && t < 200) begin
         @(negedge axis_clk);
         t++;
      end
      check("rr_start_beat", bus.awvalid, 1);
      axis_rst = 1;
      #1;
      check("rr_valids_drop", {bus.awvalid, bus.wvalid, bus.arvalid, bus.rready}, 0);
      check("rr_cmd_ready", cmd_ready, 1);
      check("rr_busy", busy, 0);
      check_log(42, 12);
      repeat (3) @(negedge axis_clk);
      axis_rst = 0;
      @(negedge axis_clk);
      check("rr_cmd_ready_after", cmd_ready, 1);
      clear_tb();
      send_cmd(600);
      feed(-1, 0);
      finish_run();
      check_log(600, 14);
      check("rr_done_cnt", done_cnt, 1);
      check("rr_err", err, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/fir_cfg_sequencer.md
# fir_cfg_sequencer

AXI4-Lite master that configures and launches the FIR engine on behalf of a local controller. Per accepted command it checks the engine is idle, writes the data length, streams in `Tape_Num` tap coefficients and writes them to the tap window, then sets and clears `ap_start`. It then polls `ap_ctrl` until `ap_done`, or until a timeout. It sits between the system controller and the FIR's AXI4-Lite slave port, on the same clock as the FIR datapath.

## Interface
- `pADDR_WIDTH`, 12, AXI-Lite address width
- `pDATA_WIDTH`, 32, data width
- `Tape_Num`, 11, number of taps written per command
- `POLL_GAP`, 4, idle cycles between consecutive status reads
- `POLL_MAX`, 1023, status reads allowed per wait phase before error

Ports:
- `axis_clk`  in  1  sole clock
- `axis_rst`  in  1  reset, asynchronous, active-high
- `cmd_valid`/`cmd_ready`  in/out  1  command handshake
- `cmd_length`  in  32  data length for the run
- `coef_valid`/`coef_ready`  in/out  1  coefficient stream handshake
- `coef_data`  in  32  tap coefficient, tap 0 first
- `awvalid`/`awready`  out/in  1  write address handshake
- `awaddr`  out  12  write address
- `wvalid`/`wready`  out/in  1  write data handshake
- `wdata`  out  32  write data
- `arvalid`/`arready`  out/in  1  read address handshake
- `araddr`  out  12  read address
- `rvalid`/`rready`  in/out  1  read data handshake
- `rdata`  in  32  read data
- `busy`  out  1  high from command accept through DONE
- `done`  out  1  one-cycle pulse on successful completion
- `err`  out  1  sticky timeout flag, cleared on next command accept

## Operation
- Register map: `0x00` ap_ctrl (bit0 start, bit1 done, bit2 idle); `0x10` length; `0x20+4*i` tap i.
- States: IDLE, CHK_RD, CHK_WAIT, WR_LEN, TAP_GET, TAP_PUT, WR_START, WR_CLR, POLL_RD, POLL_WAIT, DONE.
- IDLE:
  - `cmd_ready=1`.
  - On `cmd_valid`, latch `cmd_length`, clear `err` and the tap index, then go to CHK_RD.
- CHK_RD: read `0x00`.
  - If bit2 is set, go to WR_LEN.
  - Otherwise wait `POLL_GAP` cycles in CHK_WAIT and retry.
- WR_LEN: write the latched length to `0x10`.
- TAP_GET: `coef_ready=1`. On `coef_valid`, latch the word into the `wdata` register and go to TAP_PUT.
- TAP_PUT:
  - Write to `0x20 + 4*index`, then increment the index.
  - If `index == Tape_Num-1`, go to WR_START; otherwise go to TAP_GET.
- WR_START writes `0x1` to `0x00`. WR_CLR writes `0x0` to `0x00`.
- POLL_RD: read `0x00`.
  - If bit1 is set, go to DONE.
  - Otherwise wait `POLL_GAP` cycles in POLL_WAIT and retry.
- DONE: pulse `done` for one cycle, then return to IDLE.
- Timeout:
  - Read counter reset on entry to CHK_RD from IDLE, and on entry to POLL_RD from WR_CLR.
  - Reaching `POLL_MAX` reads sets `err`, returns to IDLE and does not pulse `done`.
- Write beat:
  - `awvalid` and `wvalid` rise together and are held with stable `awaddr`/`wdata`.
  - The beat completes only in a cycle where `awready && wready`. Both valids drop the next cycle.
  - No write response channel exists.
- Read beat:
  - `arvalid` is held until `arready`.
  - `rready` is held high from the cycle after the address handshake.
  - `rdata` is sampled on the first `rvalid && rready` in that window. Any `rvalid` before the address handshake is ignored.

## Timing
- Reset value of every output is 0, except `cmd_ready=1`. State resets to IDLE.
- All outputs are registered. `cmd_ready` and `coef_ready` are decoded from state.
- Valids assert in the first cycle of the issuing state.
- Minimum back-to-back write spacing is 2 cycles: one beat cycle plus one release cycle.
- Best case, command accept to WR_LEN beat issue is 4 cycles.
- Reset asserted mid-transaction drops all valids immediately, asynchronously, with no completion.
- Command is ignored while `busy`; `cmd_ready=0`.
- A stalled coefficient stream holds TAP_GET indefinitely, with no timeout.

## Structure
- Shared package `fir_pkg`:
  - Register offsets `FIR_AP_CTRL=12'h00`, `FIR_LENGTH=12'h10`, `FIR_TAP_BASE=12'h20`.
  - ap_ctrl bit indices.
  - State enum `fir_seq_state_t`.
- Sub-module `axil_master_port`: single-outstanding read/write beat engine with `req`/`we`/`addr`/`wdata` inputs and `ack`/`rdata` outputs. The sequencer FSM drives it.

## Test plan
- Nominal run:
  - Stimulus: slave reads idle=1; command length=600; coefficients 0..10 = {0,-10,-9,23,56,63,56,23,-9,-10,0}.
  - Required: writes in order 0x10=600, 0x20..0x48 = the coefficients, 0x00=1, 0x00=0. After the slave sets done on the 3rd poll, `done` pulses once and `err=0`.
- Not-idle:
  - Stimulus: slave returns idle=0 for 5 reads, then 1.
  - Required: no write issues until the 6th read; reads are spaced ≥ `POLL_GAP`+2 cycles.
- Back-pressure:
  - Stimulus: slave holds `wready` low for 7 cycles on the tap-3 write.
  - Required: `awaddr=0x2C` and the coefficient stay stable and valid until the handshake; no duplicate write occurs.
- Timeout:
  - Stimulus: done never sets, with `POLL_MAX=8`.
  - Required: exactly 8 status reads, then `err=1`, `done` stays 0, back to IDLE. The next command clears `err`.
- Coefficient stall:
  - Stimulus: `coef_valid` low for 20 cycles after tap 5.
  - Required: no AXI activity during the stall; resumes with tap 6 at 0x38.
- Reset mid-run:
  - Stimulus: assert `axis_rst` during the WR_START beat.
  - Required: all valids drop in the same cycle; `cmd_ready=1` after release; a fresh command completes normally.
